// File: rtl/fta_io_timeout32.sv
// Bus watchdog for the 32-bit FTA I/O segment: tracks bridge requests by tid and emits an
// error response for any request that no device answers within TIMEOUT cycles.
module fta_io_timeout32 #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned TID_W    = 13,
  parameter int unsigned PRI_W    = 4,
  localparam int unsigned CW      = $clog2(TIMEOUT + 1),
  localparam int unsigned OW      = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // Request bus, monitored only
  input  logic                      req_cyc,
  input  logic                      req_stb,
  input  logic [TID_W-1:0]          req_tid,
  input  logic [31:0]               req_padr,
  // Device response channels
  input  logic [CHANNELS-1:0]       chresp_ack,
  input  logic [CHANNELS-1:0]       chresp_err,
  input  logic [CHANNELS*TID_W-1:0] chresp_tid,
  // Synthesized timeout response
  output logic                      resp_ack_o,
  output logic                      resp_err_o,
  output logic                      resp_rty_o,
  output logic                      resp_next_o,
  output logic                      resp_stall_o,
  output logic [31:0]               resp_dat_o,
  output logic [PRI_W-1:0]          resp_pri_o,
  output logic [TID_W-1:0]          resp_tid_o,
  output logic [31:0]               resp_adr_o,
  output logic                      overflow,
  output logic [OW-1:0]             outstanding
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_valid;
  logic [TID_W-1:0] r_tid   [DEPTH];
  logic [31:0]      r_padr  [DEPTH];
  logic [CW-1:0]    r_count [DEPTH];
  logic             r_prev_hit;
  logic [TID_W-1:0] r_prev_tid;
  logic             r_err;
  logic [TID_W-1:0] r_rtid;
  logic [31:0]      r_radr;
  logic             r_overflow;
  logic [OW-1:0]    r_outstanding;

  logic             w_new;
  logic             w_hit;
  logic [DEPTH-1:0] w_retire;
  logic [DEPTH-1:0] w_emit;
  logic             w_emit_any;
  logic [IW-1:0]    w_emit_idx;
  logic [DEPTH-1:0] w_free;
  logic             w_free_any;
  logic [DEPTH-1:0] w_alloc;
  logic [DEPTH-1:0] w_valid_d;
  logic [OW-1:0]    w_cnt_d;

  // A request held across cycles with an unchanged tid is the same transaction.
  assign w_new = req_cyc & req_stb & ~(r_prev_hit & (r_prev_tid == req_tid));

  always_comb begin
    w_retire = '0;
    w_hit    = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_hit = 1'b0;
      if (chresp_ack[c] | chresp_err[c]) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!w_hit && r_valid[i] && (r_tid[i] == chresp_tid[c*TID_W +: TID_W])) begin
            w_retire[i] = 1'b1;
            w_hit       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_emit     = '0;
    w_emit_any = 1'b0;
    w_emit_idx = '0;
    w_free     = '0;
    w_free_any = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_emit_any && r_valid[i] && (r_count[i] == '0) && !w_retire[i]) begin
        w_emit[i]  = 1'b1;
        w_emit_any = 1'b1;
        w_emit_idx = IW'(i);
      end
      // Only slots free before this edge are candidates, so freed slots wait a cycle.
      if (!w_free_any && !r_valid[i]) begin
        w_free[i]  = 1'b1;
        w_free_any = 1'b1;
      end
    end
  end

  assign w_alloc   = w_new ? w_free : '0;
  assign w_valid_d = (r_valid & ~w_retire & ~w_emit) | w_alloc;

  always_comb begin
    w_cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cnt_d = w_cnt_d + OW'(w_valid_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid       <= '0;
      r_prev_hit    <= 1'b0;
      r_prev_tid    <= '0;
      r_err         <= 1'b0;
      r_rtid        <= '0;
      r_radr        <= '0;
      r_overflow    <= 1'b0;
      r_outstanding <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_tid[i]   <= '0;
        r_padr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      r_valid       <= w_valid_d;
      r_prev_hit    <= req_cyc & req_stb;
      r_prev_tid    <= req_tid;
      r_outstanding <= w_cnt_d;
      if (w_new && !w_free_any) begin
        r_overflow <= 1'b1;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_alloc[i]) begin
          r_tid[i]   <= req_tid;
          r_padr[i]  <= req_padr;
          r_count[i] <= CW'(TIMEOUT);
        end else if (r_valid[i] && (r_count[i] != '0)) begin
          r_count[i] <= r_count[i] - CW'(1);
        end
      end
      r_err  <= w_emit_any;
      r_rtid <= w_emit_any ? r_tid[w_emit_idx] : '0;
      r_radr <= w_emit_any ? r_padr[w_emit_idx] : '0;
    end
  end

  assign resp_ack_o   = 1'b0;
  assign resp_err_o   = r_err;
  assign resp_rty_o   = 1'b0;
  assign resp_next_o  = 1'b0;
  assign resp_stall_o = 1'b0;
  assign resp_dat_o   = 32'h0;
  assign resp_pri_o   = '0;
  assign resp_tid_o   = r_rtid;
  assign resp_adr_o   = r_radr;
  assign overflow     = r_overflow;
  assign outstanding  = r_outstanding;

endmodule

// File: doc/fta_io_timeout32.md
# fta_io_timeout32

Bus-watchdog for the 32-bit FTA I/O segment, sitting directly downstream of the 256→32 I/O bridge on the same `m_req` bus as the I/O devices. It records every request the bridge issues, matches it against the device response channels by `tid`, and synthesizes an error response for any request no device answers within `TIMEOUT` cycles. Its `resp_o` is wired into one slot of the bridge's `chresp` array, so an unmapped or hung I/O address completes with `err` instead of stalling the CPU forever.

## Interface
- `CHANNELS`, 2: number of device response channels monitored; excludes this block's own slot.
- `DEPTH`, 4: outstanding-request table entries.
- `TIMEOUT`, 1000: cycles before error; counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `req`  in  `fta_cmd_request32_t`  bridge-to-device request bus; monitored only, never driven.
- `chresp`  in  `fta_cmd_response32_t [CHANNELS-1:0]`  device responses; the same signals the bridge sees.
- `resp_o`  out  `fta_cmd_response32_t`  synthesized timeout response.
- `overflow`  out  1  sticky flag: a request was dropped because the table was full.
- `outstanding`  out  `$clog2(DEPTH+1)`  count of valid table entries.

## Operation
**Reset state**
- Reset clears all entries.
- Reset forces `resp_o` to all zeros, `overflow` to 0 and `outstanding` to 0.
- Reset mid-operation discards all tracked requests; no error response is emitted for them.

**New-request event**
- Fires when `req.cyc & req.stb` is true, unless the previous cycle also had `cyc & stb` with the same `tid`.
- A request held for several cycles is therefore captured once.
- Reads and writes are treated identically.

**Allocation**
- The event takes the lowest-index free entry and stores `tid`, `padr` and `count = TIMEOUT`.
- An entry freed in the same cycle is not reusable until the next cycle.
- If no entry is free, the request is dropped and `overflow` is set. `overflow` clears only on reset.

**Retire**
- Any `chresp[i].ack` or `chresp[i].err` whose `tid` matches a valid entry clears that entry.
- If several entries match, only the lowest-index one is cleared.
- Only entries that were valid before the current edge are considered.
- Multiple channels in one cycle each retire independently.

**Countdown**
- Each cycle, a valid entry with `count != 0` decrements.
- An entry at `count == 0` is "expired" and holds at 0.

**Emission**
- Each cycle, the lowest-index expired entry that is not being retired that cycle is cleared.
- Its error response is registered onto `resp_o`:
  - `err=1`; `ack`, `rty`, `next`, `stall` = 0.
  - `dat=32'h0`, `pri=0`.
  - `tid` = entry `tid`, `adr` = entry `padr`.
- Other expired entries wait; a late ack can still retire them silently.
- If nothing is emitted, `resp_o` is all zeros.

**Priority:** retire beats emission for the same entry; a simultaneous ack and expiry produces no error.

**Counter:** `outstanding` is registered. It equals the number of valid entries after the edge (allocations minus retires and emissions).

## Timing
- A request sampled at edge E0 is valid after E0 with `count = TIMEOUT`. After edge E0+k, `count = TIMEOUT-k`.
- An ack sampled at any edge up to and including E0+TIMEOUT+1 suppresses the error.
- Otherwise `resp_o.err` is high for exactly the one cycle following edge E0+TIMEOUT+1, assuming no other expired entry has priority.
- `resp_o` is a one-cycle pulse per emitted error; never two errors for one entry.
- Throughput is one allocation and one emission per cycle. Retires are unlimited, one per channel.
- The block is transparent to the bus and adds no stall or latency to normal device responses.

## Test plan
- **Normal ack:** `TIMEOUT=8`; request `tid=5`, `padr=32'hFEE00010`; `chresp[1].ack` with `tid=5` three cycles later → no `resp_o.err`; `outstanding` goes 0→1→0.
- **Unanswered request:** `TIMEOUT=8`; request `tid=3`, `padr=32'hFEF00000` at E0 → `resp_o.err=1`, `tid=3`, `adr=32'hFEF00000` only in the cycle after E0+9; `outstanding` returns to 0.
- **Boundary ack:** ack at edge E0+9 → no error. Ack at edge E0+10 → error already emitted at E0+9; the late ack is ignored and the table is unchanged.
- **Overflow:** `DEPTH=4`; five distinct tids with no responses → `overflow=1` after the fifth; four errors emitted on consecutive cycles in entry order; the fifth never errors.
- **Held request:** request with `tid=7` held for 4 cycles → one entry allocated. Then `tid` changes to 8 while `cyc` is still high → a second entry.
- **Reset:** apply reset with 3 entries pending → all outputs 0 next cycle; no error emitted after reset release.
